// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset main controller.
// State names, datapath select codes and data-processing commands.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps the data-processing cmd field to an ALU command,
// flag-write request and the CMP write suppression.
import mc_ctrl_pkg::*;

module mc_alu_dec (
  input  logic       ALUOp,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite
);

  logic [3:0] cmd;
  logic       s;

  assign cmd = Funct[4:1];
  assign s   = Funct[0];

  // Logic ops update only N/Z; arithmetic ops update all four flags
  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    if (ALUOp) begin
      unique case (cmd)
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          FlagW      = {s, s};
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          FlagW      = {s, s};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          FlagW      = {s, 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          FlagW      = {s, 1'b0};
        end
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          FlagW      = {s, s};
          NoWrite    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main controller for the multicycle core: Moore sequencer driving
// datapath enables, plus static Op decode and the ALU decoder.
import mc_ctrl_pkg::*;

module mc_ctrl_fsm #(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW
);

  state_t     state, state_nx;
  logic       ir_w, npc, reg_w, mem_w;
  logic       branch, alu_op;
  logic [1:0] fw;
  logic       nw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:  state_nx = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_nx = MEMADR;
          2'b00:   state_nx = Funct[5] ? EXECUTEI
                                       : EXECUTER;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR:   state_nx = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_nx = MEMWB;
      EXECUTER: state_nx = ALUWB;
      EXECUTEI: state_nx = ALUWB;
      default:  state_nx = FETCH;
    endcase
  end

  always_comb begin
    ir_w      = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    npc       = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    case (state)
      FETCH: begin
        ir_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        npc       = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR: ALUSrcB = SRCB_IMM;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .FlagW      (fw),
    .NoWrite    (nw)
  );

  // Enables are squashed while reset is held so no write leaks out
  assign IRWrite = ir_w  & ~reset;
  assign NextPC  = npc   & ~reset;
  assign RegW    = reg_w & ~reset;
  assign MemW    = mem_w & ~reset;
  assign FlagW   = fw & {2{~reset}};
  assign NoWrite = nw & ~reset;
  assign PCS     = (((Rd == PC_REG) & reg_w) | branch)
                   & ~reset;

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed instruction table,
// reset corner case and random instructions against a sequence model.
module tb_mc_ctrl_fsm;

  logic       clk, reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl;
  logic [1:0] ImmSrc, RegSrc, FlagW;
  logic       NoWrite, PCS, NextPC, RegW, MemW;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .FlagW      (FlagW),
    .NoWrite    (NoWrite),
    .PCS        (PCS),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [1:0] ctl;
    logic [1:0] fw;
    logic       nw;
    logic       pcs;
    logic       npc;
    logic       regw;
    logic       memw;
  } bund_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         cycles;
    logic [1:0] ctl;
    logic [1:0] fw;
    logic       nw;
    logic       pcs;
    logic       regw;
    logic       memw;
  } vec_t;

  int    n_chk = 0;
  int    n_fail = 0;
  bund_t exp_q[$];

  int         o_cyc;
  logic [1:0] o_ctl, o_fw;
  logic       o_nw, o_pcs, o_regw, o_memw;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bund_t sample();
    bund_t b;
    b.irw  = IRWrite;
    b.adr  = AdrSrc;
    b.sa   = ALUSrcA;
    b.sb   = ALUSrcB;
    b.rs   = ResultSrc;
    b.ctl  = ALUControl;
    b.fw   = FlagW;
    b.nw   = NoWrite;
    b.pcs  = PCS;
    b.npc  = NextPC;
    b.regw = RegW;
    b.memw = MemW;
    return b;
  endfunction

  // Behaviour of the data-processing commands, straight from the ISA
  task automatic alu_ref(input logic [5:0] f, output logic [1:0] ctl,
                         output logic [1:0] fw, output logic nw);
    logic s;
    s   = f[0];
    ctl = 2'd0;
    fw  = 2'd0;
    nw  = 1'b0;
    case (f[4:1])
      4'b0100: begin ctl = 2'd0; fw = {s, s}; end
      4'b0010: begin ctl = 2'd1; fw = {s, s}; end
      4'b0000: begin ctl = 2'd2; fw = {s, 1'b0}; end
      4'b1100: begin ctl = 2'd3; fw = {s, 1'b0}; end
      4'b1010: begin ctl = 2'd1; fw = {s, s}; nw = 1'b1; end
      default: ;
    endcase
  endtask

  // Expected per-cycle output list for one whole instruction
  task automatic build(input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd);
    bund_t      b;
    logic [1:0] c, w;
    logic       n;
    exp_q.delete();
    b = '0; b.irw = 1; b.sa = 1; b.sb = 2; b.rs = 2; b.npc = 1;
    exp_q.push_back(b);
    b = '0; b.sa = 1; b.sb = 2; b.rs = 2;
    exp_q.push_back(b);
    if (op == 2'd1) begin
      b = '0; b.sb = 1;
      exp_q.push_back(b);
      if (f[0]) begin
        b = '0; b.adr = 1;
        exp_q.push_back(b);
        b = '0; b.rs = 1; b.regw = 1; b.pcs = (rd == 4'd15);
        exp_q.push_back(b);
      end else begin
        b = '0; b.adr = 1; b.memw = 1;
        exp_q.push_back(b);
      end
    end else if (op == 2'd0) begin
      alu_ref(f, c, w, n);
      b = '0; b.sb = f[5] ? 2'd1 : 2'd0;
      b.ctl = c; b.fw = w; b.nw = n;
      exp_q.push_back(b);
      b = '0; b.regw = 1; b.pcs = (rd == 4'd15);
      exp_q.push_back(b);
    end else if (op == 2'd2) begin
      b = '0; b.sb = 1; b.rs = 2; b.pcs = 1;
      exp_q.push_back(b);
    end
  endtask

  // Called at posedge+1 of a FETCH cycle; returns at the next FETCH
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd);
    bund_t got;
    int    n;
    bit    done;
    build(op, f, rd);
    Op = op; Funct = f; Rd = rd;
    n = 0; done = 0;
    o_ctl = 0; o_fw = 0; o_nw = 0;
    o_pcs = 0; o_regw = 0; o_memw = 0;
    while (!done) begin
      @(negedge clk);
      got = sample();
      if (n < exp_q.size())
        if (got != exp_q[n]) begin
          n_fail++;
          $display("FAIL cyc%0d op=%0d f=%b rd=%0d: got %h expected %h",
                   n, op, f, rd, got, exp_q[n]);
        end
      n_chk++;
      chk("ImmSrc", ImmSrc, op);
      chk("RegSrc", RegSrc, {op == 2'd1, op == 2'd2});
      o_ctl |= got.ctl; o_fw |= got.fw; o_nw |= got.nw;
      o_pcs |= got.pcs; o_regw |= got.regw; o_memw |= got.memw;
      n++;
      @(posedge clk); #1;
      if (IRWrite || n >= 8) done = 1;
    end
    o_cyc = n;
    chk("cycles", n, exp_q.size());
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{2'd1, 6'b011001, 4'd3,  5, 2'd0, 2'd0, 0, 0, 1, 0};
    vecs[1]  = '{2'd1, 6'b011000, 4'd3,  4, 2'd0, 2'd0, 0, 0, 0, 1};
    vecs[2]  = '{2'd0, 6'b000101, 4'd2,  4, 2'd1, 2'd3, 0, 0, 1, 0};
    vecs[3]  = '{2'd0, 6'b110101, 4'd0,  4, 2'd1, 2'd3, 1, 0, 1, 0};
    vecs[4]  = '{2'd0, 6'b000001, 4'd1,  4, 2'd2, 2'd2, 0, 0, 1, 0};
    vecs[5]  = '{2'd0, 6'b011000, 4'd4,  4, 2'd3, 2'd0, 0, 0, 1, 0};
    vecs[6]  = '{2'd0, 6'b001000, 4'd15, 4, 2'd0, 2'd0, 0, 1, 1, 0};
    vecs[7]  = '{2'd2, 6'b000000, 4'd0,  3, 2'd0, 2'd0, 0, 1, 0, 0};
    vecs[8]  = '{2'd3, 6'b111111, 4'd15, 2, 2'd0, 2'd0, 0, 0, 0, 0};
    vecs[9]  = '{2'd1, 6'b011001, 4'd15, 5, 2'd0, 2'd0, 0, 1, 1, 0};
    vecs[10] = '{2'd0, 6'b001111, 4'd5,  4, 2'd0, 2'd0, 0, 0, 1, 0};

    reset = 1'b1; Op = 2'd0; Funct = 6'd0; Rd = 4'd0;
    #3;
    chk("rst_IRWrite", IRWrite, 0);
    chk("rst_NextPC", NextPC, 0);
    chk("rst_RegW", RegW, 0);
    chk("rst_MemW", MemW, 0);
    chk("rst_ALUSrcB", ALUSrcB, 2);
    chk("rst_ResultSrc", ResultSrc, 2);
    chk("rst_ALUSrcA", ALUSrcA, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].funct, vecs[i].rd);
      chk($sformatf("v%0d_cycles", i), o_cyc, vecs[i].cycles);
      chk($sformatf("v%0d_ctl", i), o_ctl, vecs[i].ctl);
      chk($sformatf("v%0d_flagw", i), o_fw, vecs[i].fw);
      chk($sformatf("v%0d_nowrite", i), o_nw, vecs[i].nw);
      chk($sformatf("v%0d_pcs", i), o_pcs, vecs[i].pcs);
      chk($sformatf("v%0d_regw", i), o_regw, vecs[i].regw);
      chk($sformatf("v%0d_memw", i), o_memw, vecs[i].memw);
    end

    // Reset dropped on the store write cycle
    Op = 2'd1; Funct = 6'b011000; Rd = 4'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("memwr_MemW", MemW, 1);
    chk("memwr_AdrSrc", AdrSrc, 1);
    reset = 1'b1;
    #1;
    chk("midrst_MemW", MemW, 0);
    chk("midrst_RegW", RegW, 0);
    chk("midrst_IRWrite", IRWrite, 0);
    chk("midrst_NextPC", NextPC, 0);
    chk("midrst_ALUSrcB", ALUSrcB, 2);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_IRWrite", IRWrite, 1);
    chk("post_NextPC", NextPC, 1);
    chk("post_MemW", MemW, 0);
    Op = 2'd3;
    @(posedge clk); #1;
    chk("post_decode_IRWrite", IRWrite, 0);
    @(posedge clk); #1;
    chk("post_fetch_IRWrite", IRWrite, 1);

    for (int k = 0; k < 200; k++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15
                                       : 4'($urandom_range(0, 15));
      run_instr(op, f, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
